// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg
// Shared types for the 1R1W bank responder and its read-delay pipe.
//   bank_state_e : bank FSM states (INIT walks the array, RDY serves accesses)
//   err_tag_e    : per-row error tag stored beside each data word
//   pipe_slot_t  : one read result travelling down the delay pipe
// The slot field widths are fixed here and must be at least the bank's
// WIDTH / BITVROW; the bank zero-extends into them and slices back out.
package mem_bank_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_ADDR_W = 10;

    typedef enum logic {
        INIT = 1'b0,
        RDY  = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_SERR = 2'b01,
        TAG_DERR = 2'b10,
        TAG_CLR  = 2'b11
    } err_tag_e;

    typedef struct packed {
        logic                   vld;
        logic [PIPE_DATA_W-1:0] data;
        logic                   fwrd;
        err_tag_e               tag;
        logic [PIPE_ADDR_W-1:0] padr;
    } pipe_slot_t;

endpackage

// File: rtl/bank_rd_delay.sv
// bank_rd_delay
// DEPTH-stage shift register of read-result slots. A slot entering on
// one clock edge appears on slot_out DEPTH edges later. The asynchronous
// clear empties every stage so in-flight reads vanish at once on reset.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low clear
//   slot_in  : slot captured into stage 0 every cycle (may be empty)
//   slot_out : contents of the last stage
module bank_rd_delay
    import mem_bank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  pipe_slot_t slot_in,
    output pipe_slot_t slot_out
);

    pipe_slot_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= slot_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign slot_out = stage[DEPTH-1];

endmodule

// File: rtl/sram_1r1w_bank_resp.sv
// sram_1r1w_bank_resp
// One 1R1W memory bank answering a t1_* bank slice of the multi-port core.
// After reset the bank clears every row (data 0, tag none), then raises
// ready and accepts one write (port A) and one read (port B) per cycle.
// Read results return SRAM_DELAY cycles after issue with forward,
// single-error, double-error and physical-row status. Error tags are set
// through the injection port so serr/derr can be produced on demand.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   t1_writeA/addrA/dinA        : write strobe, row, data
//   t1_readB/addrB              : read strobe, row
//   t1_doutB/fwrdB/serrB/derrB  : read data, forwarded, single/double error
//   t1_padrB                    : physical row of the returned read
//   inj_valid/inj_addr/inj_type : error-tag injection (00 no-op, 11 clear)
//   ready                       : initialisation finished
module sram_1r1w_bank_resp
    import mem_bank_pkg::*;
#(
    parameter int WIDTH      = PIPE_DATA_W,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = PIPE_ADDR_W,
    parameter int SRAM_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               t1_writeA,
    input  logic [BITVROW-1:0] t1_addrA,
    input  logic [WIDTH-1:0]   t1_dinA,
    input  logic               t1_readB,
    input  logic [BITVROW-1:0] t1_addrB,
    output logic [WIDTH-1:0]   t1_doutB,
    output logic               t1_fwrdB,
    output logic               t1_serrB,
    output logic               t1_derrB,
    output logic [BITVROW-1:0] t1_padrB,
    input  logic               inj_valid,
    input  logic [BITVROW-1:0] inj_addr,
    input  logic [1:0]         inj_type,
    output logic               ready
);

    // The counter carries one extra bit so NUMVROW = 2^BITVROW still compares
    // cleanly against the last row without wrapping.
    localparam logic [BITVROW:0] ROWS     = (BITVROW + 1)'(NUMVROW);
    localparam logic [BITVROW:0] LAST_ROW = ROWS - 1'b1;

    logic [WIDTH-1:0] mem     [NUMVROW];
    err_tag_e         tag_mem [NUMVROW];

    bank_state_e      state;
    logic [BITVROW:0] init_cnt;

    logic             addr_a_ok;
    logic             addr_b_ok;
    logic             inj_ok;
    logic             collide;

    logic             wr_en;
    logic [BITVROW-1:0] wr_row;
    logic [WIDTH-1:0] wr_data;
    logic             inj_en;
    logic [BITVROW-1:0] inj_row;
    err_tag_e         inj_tag;

    pipe_slot_t       rd_in;
    pipe_slot_t       rd_out;

    assign addr_a_ok = ({1'b0, t1_addrA} < ROWS);
    assign addr_b_ok = ({1'b0, t1_addrB} < ROWS);
    assign inj_ok    = ({1'b0, inj_addr} < ROWS);
    assign collide   = (state == RDY) && t1_writeA && addr_a_ok && (t1_addrA == t1_addrB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ROW) begin
                        state <= RDY;
                        ready <= 1'b1;
                    end
                end
                RDY: begin
                    state <= RDY;
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // During INIT the array port is owned by the clearing walk and every
    // external request is ignored.
    always_comb begin
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        inj_en  = 1'b0;
        inj_row = '0;
        inj_tag = TAG_NONE;
        if (state == INIT) begin
            wr_en  = 1'b1;
            wr_row = init_cnt[BITVROW-1:0];
        end else begin
            wr_en   = t1_writeA && addr_a_ok;
            wr_row  = t1_addrA;
            wr_data = t1_dinA;
            inj_en  = inj_valid && (inj_type != 2'b00) && inj_ok;
            inj_row = inj_addr;
            inj_tag = err_tag_e'(inj_type);
        end
    end

    // The injection assignment comes last so it overrides the tag clear of
    // a same-cycle write to the same row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row]     <= wr_data;
            tag_mem[wr_row] <= TAG_NONE;
        end
        if (inj_en) begin
            tag_mem[inj_row] <= inj_tag;
        end
    end

    // Reads sample the array before this edge's updates land, so a
    // same-row write must be forwarded and a same-row injection is not
    // yet visible to the read.
    always_comb begin
        rd_in = '0;
        if ((state == RDY) && t1_readB) begin
            rd_in.vld  = 1'b1;
            rd_in.padr = PIPE_ADDR_W'(t1_addrB);
            if (addr_b_ok) begin
                if (collide) begin
                    rd_in.data = PIPE_DATA_W'(t1_dinA);
                    rd_in.fwrd = 1'b1;
                    rd_in.tag  = TAG_NONE;
                end else begin
                    rd_in.data = PIPE_DATA_W'(mem[t1_addrB]);
                    rd_in.tag  = tag_mem[t1_addrB];
                end
            end
        end
    end

    bank_rd_delay #(
        .DEPTH (SRAM_DELAY)
    ) u_rd_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_in  (rd_in),
        .slot_out (rd_out)
    );

    assign t1_doutB = rd_out.vld ? rd_out.data[WIDTH-1:0] : '0;
    assign t1_fwrdB = rd_out.vld && rd_out.fwrd;
    assign t1_serrB = rd_out.vld && (rd_out.tag == TAG_SERR);
    assign t1_derrB = rd_out.vld && (rd_out.tag == TAG_DERR);
    assign t1_padrB = rd_out.vld ? rd_out.padr[BITVROW-1:0] : '0;

endmodule

// File: tb/tb_sram_1r1w_bank_resp.sv
// tb_sram_1r1w_bank_resp
// Directed bench for sram_1r1w_bank_resp. Reads are registered with a
// hand-computed expected result that is compared on the exact cycle it
// is due (issue cycle + DELAY).
module tb_sram_1r1w_bank_resp;

    localparam int WIDTH   = 32;
    localparam int NUMVROW = 1024;
    localparam int BITVROW = 10;
    localparam int DELAY   = 2;

    logic               clk;
    logic               rst_n;
    logic               t1_writeA;
    logic [BITVROW-1:0] t1_addrA;
    logic [WIDTH-1:0]   t1_dinA;
    logic               t1_readB;
    logic [BITVROW-1:0] t1_addrB;
    logic [WIDTH-1:0]   t1_doutB;
    logic               t1_fwrdB;
    logic               t1_serrB;
    logic               t1_derrB;
    logic [BITVROW-1:0] t1_padrB;
    logic               inj_valid;
    logic [BITVROW-1:0] inj_addr;
    logic [1:0]         inj_type;
    logic               ready;

    sram_1r1w_bank_resp #(
        .WIDTH      (WIDTH),
        .NUMVROW    (NUMVROW),
        .BITVROW    (BITVROW),
        .SRAM_DELAY (DELAY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .t1_writeA (t1_writeA),
        .t1_addrA  (t1_addrA),
        .t1_dinA   (t1_dinA),
        .t1_readB  (t1_readB),
        .t1_addrB  (t1_addrB),
        .t1_doutB  (t1_doutB),
        .t1_fwrdB  (t1_fwrdB),
        .t1_serrB  (t1_serrB),
        .t1_derrB  (t1_derrB),
        .t1_padrB  (t1_padrB),
        .inj_valid (inj_valid),
        .inj_addr  (inj_addr),
        .inj_type  (inj_type),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        int                 id;
        logic [WIDTH-1:0]   data;
        logic               fwrd;
        logic               serr;
        logic               derr;
        logic [BITVROW-1:0] padr;
    } exp_t;

    exp_t pending[$];
    int   testCount = 0;
    int   failCount = 0;
    int   cycle     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wa, input logic [BITVROW-1:0] aa, input logic [WIDTH-1:0] da,
                                 input logic rb, input logic [BITVROW-1:0] ab,
                                 input logic iv, input logic [BITVROW-1:0] ia, input logic [1:0] it);
        t1_writeA = wa;
        t1_addrA  = aa;
        t1_dinA   = da;
        t1_readB  = rb;
        t1_addrB  = ab;
        inj_valid = iv;
        inj_addr  = ia;
        inj_type  = it;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 2'b00);
    endtask

    // Called in the issue cycle of a read.
    task automatic expectRead(input int id, input logic [WIDTH-1:0] data, input logic fwrd,
                              input logic serr, input logic derr, input logic [BITVROW-1:0] padr);
        exp_t e;
        e.due  = cycle + DELAY;
        e.id   = id;
        e.data = data;
        e.fwrd = fwrd;
        e.serr = serr;
        e.derr = derr;
        e.padr = padr;
        pending.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        while (pending.size() > 0 && pending[0].due == cycle) begin
            e = pending.pop_front();
            checkOutput($sformatf("rd%0d_data", e.id), t1_doutB, e.data);
            checkOutput($sformatf("rd%0d_fwrd", e.id), 32'(t1_fwrdB), 32'(e.fwrd));
            checkOutput($sformatf("rd%0d_serr", e.id), 32'(t1_serrB), 32'(e.serr));
            checkOutput($sformatf("rd%0d_derr", e.id), 32'(t1_derrB), 32'(e.derr));
            checkOutput($sformatf("rd%0d_padr", e.id), 32'(t1_padrB), 32'(e.padr));
        end
    endtask

    task automatic drain();
        idle();
        repeat (DELAY) step();
    endtask

    // Issue one read now and drain it.
    task automatic readRow(input int id, input logic [BITVROW-1:0] row, input logic [WIDTH-1:0] data,
                           input logic serr, input logic derr);
        applyStimulus(1'b0, '0, '0, 1'b1, row, 1'b0, '0, 2'b00);
        expectRead(id, data, 1'b0, serr, derr, row);
        step();
        drain();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_dout", t1_doutB, 32'd0);
        checkOutput("rst_fwrd", 32'(t1_fwrdB), 32'd0);
        checkOutput("rst_serr", 32'(t1_serrB), 32'd0);
        checkOutput("rst_derr", 32'(t1_derrB), 32'd0);
        checkOutput("rst_padr", 32'(t1_padrB), 32'd0);

        // Release in cycle 0; accesses during init must be ignored.
        rst_n = 1'b1;
        cycle = 0;
        checkOutput("init_ready_c0", 32'(ready), 32'd0);
        for (int n = 1; n < NUMVROW; n++) begin
            step();
            if (n == 900) applyStimulus(1'b1, 10'd5, 32'h5555_5555, 1'b1, 10'd5, 1'b1, 10'd5, 2'b01);
            if (n == 901) idle();
            if (n == 900 + DELAY) begin
                checkOutput("init_rd_dout", t1_doutB, 32'd0);
                checkOutput("init_rd_padr", 32'(t1_padrB), 32'd0);
            end
        end
        checkOutput("init_ready_last", 32'(ready), 32'd0);
        step();
        checkOutput("ready_rise", 32'(ready), 32'd1);

        // Row 5 is clean: init-time write/inject must have been dropped.
        readRow(1, 10'd5, 32'd0, 1'b0, 1'b0);
        step();
        checkOutput("empty_dout", t1_doutB, 32'd0);
        checkOutput("empty_padr", 32'(t1_padrB), 32'd0);

        // Write then read next cycle.
        applyStimulus(1'b1, 10'd3, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0, 2'b00);
        step();
        readRow(2, 10'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Same-cycle collision forwards, then the stored copy is read.
        applyStimulus(1'b1, 10'd7, 32'h0000_1234, 1'b1, 10'd7, 1'b0, '0, 2'b00);
        expectRead(3, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 10'd7);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd7, 1'b0, '0, 2'b00);
        expectRead(4, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 10'd7);
        step();
        drain();

        // Different rows in one cycle do not interact.
        applyStimulus(1'b1, 10'd10, 32'h0000_1010, 1'b1, 10'd11, 1'b0, '0, 2'b00);
        expectRead(5, 32'd0, 1'b0, 1'b0, 1'b0, 10'd11);
        step();
        drain();

        // Error-tag handling on row 9.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'd9, 2'b01);
        step();
        readRow(6, 10'd9, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'd9, 2'b10);
        step();
        readRow(7, 10'd9, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 10'd9, 32'h0000_0099, 1'b0, '0, 1'b0, '0, 2'b00);
        step();
        readRow(8, 10'd9, 32'h0000_0099, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd9, 32'h0000_00AA, 1'b0, '0, 1'b1, 10'd9, 2'b10);
        step();
        readRow(9, 10'd9, 32'h0000_00AA, 1'b0, 1'b1);
        // Read and inject in one cycle: read sees the old derr tag.
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd9, 1'b1, 10'd9, 2'b01);
        expectRead(10, 32'h0000_00AA, 1'b0, 1'b0, 1'b1, 10'd9);
        step();
        drain();
        readRow(11, 10'd9, 32'h0000_00AA, 1'b1, 1'b0);
        // Type 00 leaves the tag alone; 11 clears it.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'd9, 2'b00);
        step();
        readRow(12, 10'd9, 32'h0000_00AA, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'd9, 2'b11);
        step();
        readRow(13, 10'd9, 32'h0000_00AA, 1'b0, 1'b0);

        // Back-to-back streaming of rows 0..15.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 10'(i), 32'hC0DE_0000 + 32'(i), 1'b0, '0, 1'b0, '0, 2'b00);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 10'(i), 1'b0, '0, 2'b00);
            expectRead(100 + i, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 10'(i));
            step();
        end
        drain();

        // Stream again and reset while the pipe is full.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 10'(i + 8), 1'b0, '0, 2'b00);
            expectRead(200 + i, 32'hC0DE_0008 + 32'(i), 1'b0, 1'b0, 1'b0, 10'(i + 8));
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        pending.delete();
        idle();
        checkOutput("midrst_dout", t1_doutB, 32'd0);
        checkOutput("midrst_padr", 32'(t1_padrB), 32'd0);
        checkOutput("midrst_ready", 32'(ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle = 0;
        repeat (NUMVROW - 1) step();
        checkOutput("reinit_ready_last", 32'(ready), 32'd0);
        step();
        checkOutput("reinit_ready_rise", 32'(ready), 32'd1);
        readRow(14, 10'd0, 32'd0, 1'b0, 1'b0);
        readRow(15, 10'd15, 32'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
